shift_rows_pipe: RTL and testbench
==================================

// Module: shift_rows_pipe
// PURPOSE
//  Registered, parametrised Rijndael ShiftRows / InvShiftRows stage with valid/ready flow control.
//  Supports block sizes Nb = 4, 6 or 8 columns; direction is selected per transaction.
//  Sits between SubBytes and MixColumns in the round datapath (forward),
//  or between InvSubBytes and AddRoundKey (inverse).
//  A 2-entry skid buffer gives 1-cycle latency and full throughput without a combinational ready path.
// PARAMETERS
//  NB      4  state columns; legal 4, 6, 8; any other value is an elaboration error
//  BYTE_W  8  bits per state cell
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               asynchronous reset, active-low
//  in_valid   in   1               input beat valid
//  in_ready   out  1               stage can accept a beat
//  in_inv     in   1               0 = ShiftRows, 1 = InvShiftRows; sampled with the beat
//  in_state   in   4*NB*BYTE_W     state; cell (c,r) at bits [(c*4+r)*BYTE_W +: BYTE_W]
//  out_valid  out  1               output beat valid
//  out_ready  in   1               downstream accepts the beat
//  out_state  out  4*NB*BYTE_W     shifted state, same packing as in_state
//  out_inv    out  1               direction flag carried with the beat
// BEHAVIOUR
//  Row offsets off(r), r = 0..3:
//   - NB = 4 or 6: 0,1,2,3
//   - NB = 8:      0,1,3,4
//  Mapping:
//   - Forward: out(c,r) = in((c + off(r)) mod NB, r)
//   - Inverse: out(c,r) = in((c - off(r) + NB) mod NB, r)
//   - Pure wiring permutation; no arithmetic beyond constant index mod NB.
//  Storage: main register M and skid register S, each {state, inv, valid}.
//  Transform is applied before capture, so M and S hold shifted data.
//  Reset (rst low, async): M.valid = S.valid = 0; out_valid = 0; in_ready = 1;
//   out_state = 0; out_inv = 0.
//  Data registers clear on reset. Reset mid-transfer drops in-flight beats silently.
//  in_ready = !S.valid (registered; no combinational path from out_ready).
//  A beat is accepted when in_valid && in_ready, and emitted when out_valid && out_ready.
//  Outputs drive from M: out_valid = M.valid.
//  State machine (occupancy):
//   - EMPTY (M,S empty):
//     - accept -> ONE.
//   - ONE (M full, S empty):
//     - accept & emit -> M takes the new beat, stay ONE.
//     - accept & no emit -> new beat goes to S, go to FULL.
//     - emit only -> EMPTY.
//     - neither -> hold.
//   - FULL (M,S full; in_ready = 0):
//     - emit -> M takes S, S clears, go to ONE.
//     - no emit -> hold.
//     - in_valid is ignored in FULL.
//  Latency: a beat accepted at edge k is on out_state after edge k; first emit possible in cycle k+1.
//  Ordering: strict FIFO. Beat content and in_inv never change while out_valid && !out_ready.
//  Throughput: 1 beat/cycle when out_ready is held high.
//  in_state and in_inv are don't-care when in_valid = 0.
// TESTING
//  1. NB=4 fwd, in cell(c,r) = 16*c+r, out_ready=1
//     -> cycle+1 out(0,*) = 00,11,22,33; out(1,*) = 10,21,32,03.
//  2. NB=4 inv on the test 1 output -> original 00..33 restored; out_inv = 1.
//  3. NB=8 fwd, cell = 16*c+r -> out(0,*) = 00,11,32,43; out(7,*) = 70,01,22,33.
//  4. Backpressure: 3 back-to-back beats A,B,C with out_ready=0
//     -> A held on out, B in skid, in_ready=0 after edge 2, C stalled.
//     Then raise out_ready -> A,B,C emitted in order, no loss or duplicate.
//  5. Alternate in_inv 0/1 each beat at full rate, NB=6
//     -> each out_inv matches its beat; fwd then inv round-trips to the input.
//  6. Assert rst low while FULL -> out_valid=0, in_ready=1 immediately (async).
//     After release, first new beat emerges one cycle after accept.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe
//
// Registered Rijndael ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8
// columns. Direction is chosen per beat. A two-entry skid buffer (main
// register M plus skid register S) gives one cycle of latency and full
// throughput. in_ready comes only from registered state, so there is no
// combinational path from out_ready to in_ready.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   in_valid   input beat valid
//   in_ready   stage can accept a beat
//   in_inv     0 = ShiftRows, 1 = InvShiftRows, sampled with the beat
//   in_state   state; cell (c,r) at bits [(c*4+r)*BYTE_W +: BYTE_W]
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_state  shifted state, same packing as in_state
//   out_inv    direction flag carried with the beat
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high. Once valid is raised it stays high, with stable
// payload, until that edge. in_ready never depends on in_valid, and
// out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int BYTE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_inv,
    input  logic [4*NB*BYTE_W-1:0]   in_state,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4*NB*BYTE_W-1:0]   out_state,
    output logic                     out_inv
);

    localparam int W = 4 * NB * BYTE_W;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
    endgenerate

    // Occupancy FSM. EMPTY: M and S empty. ONE: M full. FULL: M and S full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    m_state_q, m_state_d;
    logic            m_inv_q, m_inv_d;
    logic [W-1:0]    s_state_q, s_state_d;
    logic            s_inv_q, s_inv_d;

    logic            accept;
    logic            emit;
    logic [W-1:0]    in_xf;

    // Row rotation amounts. Wide blocks (Nb = 8) use 0,1,3,4.
    function automatic int row_off(input int r);
        int off;
        case (r)
            0:       off = 0;
            1:       off = 1;
            2:       off = (NB == 8) ? 3 : 2;
            default: off = (NB == 8) ? 4 : 3;
        endcase
        return off;
    endfunction

    // Constant-index permutation. After the loops unroll this is wiring only.
    function automatic logic [W-1:0] shift_state(input logic [W-1:0] st,
                                                 input logic inv);
        logic [W-1:0] res;
        int           src;
        res = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) src = (c - row_off(r) + NB) % NB;
                else     src = (c + row_off(r)) % NB;
                res[(c*4+r)*BYTE_W +: BYTE_W] = st[(src*4+r)*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_state = m_state_q;
    assign out_inv   = m_inv_q;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;
    assign in_xf  = shift_state(in_state, in_inv);

    always_comb begin
        state_d   = state_q;
        m_state_d = m_state_q;
        m_inv_d   = m_inv_q;
        s_state_d = s_state_q;
        s_inv_d   = s_inv_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    m_state_d = in_xf;
                    m_inv_d   = in_inv;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    m_state_d = in_xf;
                    m_inv_d   = in_inv;
                end else if (accept) begin
                    // Downstream is stalled, so park the new beat in the skid.
                    s_state_d = in_xf;
                    s_inv_d   = in_inv;
                    state_d   = ST_FULL;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so in_valid has no effect.
                if (emit) begin
                    m_state_d = s_state_q;
                    m_inv_d   = s_inv_q;
                    state_d   = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_EMPTY;
            m_state_q <= '0;
            m_inv_q   <= 1'b0;
            s_state_q <= '0;
            s_inv_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_state_q <= m_state_d;
            m_inv_q   <= m_inv_d;
            s_state_q <= s_state_d;
            s_inv_q   <= s_inv_d;
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_rows_pipe
//
// Bench for shift_rows_pipe. It drives three instances (NB = 4, 6, 8) from
// one set of stimulus signals. The variable nb picks which instance is active.
// Expected beats are pushed when a beat is accepted and popped when a beat is
// emitted. Inputs change on the falling edge, and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_shift_rows_pipe;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus / observation ----------------
    int           nb;
    logic         in_valid;
    logic         in_inv;
    logic [255:0] in_state;
    logic         out_ready;
    logic         rand_rdy;

    logic         obs_in_ready;
    logic         obs_out_valid;
    logic         obs_out_inv;
    logic [255:0] obs_out_state;

    logic         v4, v6, v8, or4, or6, or8;
    logic         ir4, ir6, ir8, ov4, ov6, ov8, oi4, oi6, oi8;
    logic [127:0] os4;
    logic [191:0] os6;
    logic [255:0] os8;

    assign v4  = in_valid && (nb == 4);
    assign v6  = in_valid && (nb == 6);
    assign v8  = in_valid && (nb == 8);
    assign or4 = (nb == 4) ? out_ready : 1'b1;
    assign or6 = (nb == 6) ? out_ready : 1'b1;
    assign or8 = (nb == 8) ? out_ready : 1'b1;

    shift_rows_pipe #(.NB(4), .BYTE_W(8)) u_nb4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(ir4), .in_inv(in_inv), .in_state(in_state[127:0]),
        .out_valid(ov4), .out_ready(or4), .out_state(os4), .out_inv(oi4)
    );
    shift_rows_pipe #(.NB(6), .BYTE_W(8)) u_nb6 (
        .clk(clk), .rst(rst),
        .in_valid(v6), .in_ready(ir6), .in_inv(in_inv), .in_state(in_state[191:0]),
        .out_valid(ov6), .out_ready(or6), .out_state(os6), .out_inv(oi6)
    );
    shift_rows_pipe #(.NB(8), .BYTE_W(8)) u_nb8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(ir8), .in_inv(in_inv), .in_state(in_state),
        .out_valid(ov8), .out_ready(or8), .out_state(os8), .out_inv(oi8)
    );

    always_comb begin
        obs_in_ready  = ir4;
        obs_out_valid = ov4;
        obs_out_inv   = oi4;
        obs_out_state = {128'b0, os4};
        if (nb == 6) begin
            obs_in_ready  = ir6;
            obs_out_valid = ov6;
            obs_out_inv   = oi6;
            obs_out_state = {64'b0, os6};
        end else if (nb == 8) begin
            obs_in_ready  = ir8;
            obs_out_valid = ov8;
            obs_out_inv   = oi8;
            obs_out_state = os8;
        end
    end

    // ---------------- scoreboard ----------------
    logic [256:0] exp_q[$];   // {inv, state}
    int checks;
    int errors;

    // Reference model of the permutation.
    function automatic logic [255:0] model(input int n, input logic [255:0] st,
                                           input logic inv);
        logic [255:0] m;
        int off;
        int src;
        m = '0;
        for (int c = 0; c < n; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (r < 2)       off = r;
                else if (n == 8) off = r + 1;
                else             off = r;
                src = inv ? ((c - off + n) % n) : ((c + off) % n);
                m[(c*4+r)*8 +: 8] = st[(src*4+r)*8 +: 8];
            end
        end
        return m;
    endfunction

    function automatic logic [255:0] pat(input int n);
        logic [255:0] p;
        p = '0;
        for (int c = 0; c < n; c++)
            for (int r = 0; r < 4; r++)
                p[(c*4+r)*8 +: 8] = 8'(16*c + r);
        return p;
    endfunction

    function automatic logic [255:0] rnd_state(input int n);
        logic [255:0] p;
        p = '0;
        for (int i = 0; i < n; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic check(input string tag, input logic [256:0] obs,
                         input logic [256:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already set. Scores any beat that
    // the coming rising edge will transfer, then advances one cycle.
    task automatic cycle();
        logic [256:0] e;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        if (obs_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_spurious", {1'b0, 256'b1}, 257'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_beat", {obs_out_inv, obs_out_state}, e);
            end
        end
        if (in_valid && obs_in_ready)
            exp_q.push_back({in_inv, model(nb, in_state, in_inv)});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [255:0] st, input logic inv);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_state = st;
        in_inv   = inv;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = obs_in_ready;
            cycle();
        end
        in_valid = 1'b0;
        check("send_accept", {256'b0, acc}, 257'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycle();
        check("drain_empty", 257'(exp_q.size()), 257'd0);
    endtask

    // ---------------- directed sequence ----------------
    logic [255:0] t1;
    logic [255:0] a_st, b_st, c_st, x_st;

    initial begin
        rst       = 1'b0;
        nb        = 4;
        in_valid  = 1'b0;
        in_inv    = 1'b0;
        in_state  = '0;
        out_ready = 1'b1;
        rand_rdy  = 1'b0;
        checks    = 0;
        errors    = 0;

        // Reset state.
        #1;
        check("rst_out_valid", {256'b0, obs_out_valid}, 257'd0);
        check("rst_in_ready",  {256'b0, obs_in_ready},  257'd1);
        check("rst_out_state", {1'b0, obs_out_state},  257'd0);
        check("rst_out_inv",   {256'b0, obs_out_inv},   257'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Test 1: NB=4 forward on the 16*c+r pattern.
        send(pat(4), 1'b0);
        check("t1_valid", {256'b0, obs_out_valid}, 257'd1);
        check("t1_col0",  257'(obs_out_state[31:0]),  257'h33221100);
        check("t1_col1",  257'(obs_out_state[63:32]), 257'h03322110);
        t1 = obs_out_state;

        // Test 2: inverse of the test 1 output restores the input.
        send(t1, 1'b1);
        check("t2_restore", {obs_out_inv, obs_out_state}, {1'b1, pat(4)});
        drain();

        // Test 3: NB=8 forward.
        nb = 8;
        send(pat(8), 1'b0);
        check("t3_col0", 257'(obs_out_state[31:0]),    257'h43321100);
        check("t3_col7", 257'(obs_out_state[255:224]), 257'h33220170);
        drain();

        // Test 4: backpressure on NB=4 with three back-to-back beats.
        nb        = 4;
        out_ready = 1'b0;
        a_st = rnd_state(4);
        b_st = rnd_state(4);
        c_st = rnd_state(4);
        send(a_st, 1'b0);
        send(b_st, 1'b1);
        check("t4_in_ready_low", {256'b0, obs_in_ready}, 257'd0);
        in_valid = 1'b1;
        in_state = c_st;
        in_inv   = 1'b0;
        cycle();
        cycle();
        in_valid = 1'b0;
        check("t4_a_held", {obs_out_valid, obs_out_inv, obs_out_state[254:0]},
              {1'b1, 1'b0, model(4, a_st, 1'b0)[254:0]});
        check("t4_depth", 257'(exp_q.size()), 257'd2);
        out_ready = 1'b1;
        send(c_st, 1'b0);
        drain();

        // Test 5: NB=6, alternating direction at full rate, fwd then inv.
        nb = 6;
        for (int i = 0; i < 6; i++) begin
            x_st = rnd_state(6);
            in_valid = 1'b1;
            in_state = x_st;
            in_inv   = 1'b0;
            cycle();
            in_state = model(6, x_st, 1'b0);
            in_inv   = 1'b1;
            cycle();
            check("t5_roundtrip", {obs_out_inv, obs_out_state},
                  {1'b1, x_st});
        end
        in_valid = 1'b0;
        drain();

        // Random stress on NB=8 with random out_ready.
        nb       = 8;
        rand_rdy = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send(rnd_state(8), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) cycle();
        end
        drain();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;

        // Test 6: asynchronous reset while FULL.
        nb        = 4;
        out_ready = 1'b0;
        send(rnd_state(4), 1'b0);
        send(rnd_state(4), 1'b1);
        check("t6_full", {256'b0, obs_in_ready}, 257'd0);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_out_valid", {256'b0, obs_out_valid}, 257'd0);
        check("t6_rst_in_ready",  {256'b0, obs_in_ready},  257'd1);
        check("t6_rst_out_state", {1'b0, obs_out_state},  257'd0);
        exp_q.delete();
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        c_st = rnd_state(4);
        send(c_st, 1'b1);
        check("t6_first_beat", {obs_out_valid, obs_out_inv, obs_out_state[254:0]},
              {1'b1, 1'b1, model(4, c_st, 1'b1)[254:0]});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
